// File: rtl/dram_arb_pkg.sv
// Shared types and limits for the DRAM port arbiter: lock FSM states and
// channel-id width helper.
package dram_arb_pkg;

    localparam int MIN_CH     = 2;
    localparam int MAX_CH     = 8;
    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 3;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // A channel id needs at least one bit even for the smallest configuration.
    function automatic int ch_id_w(input int n);
        return (n <= MIN_CH) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin picker: grants the first masked requester strictly
// above the pointer, wrapping to the lowest requester otherwise.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt
);

    logic [N-1:0] w_req;
    logic [N-1:0] w_above;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    assign w_req = i_req & i_mask;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_above
            assign w_above[gi] = (gi > int'(i_ptr));
        end
    endgenerate

    assign w_hi  = w_req & w_above;
    assign w_sel = (|w_hi) ? w_hi : w_req;
    // Isolate the lowest set bit of the selected half.
    assign o_gnt = w_sel & (-w_sel);

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin sharing of one synchronous single-port DRAM among NUM_CH masters.
// Define DRAM_ARB_LOCK_EN to add the lock port and exclusive-ownership FSM.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wren,
    input  logic [DATA_W-1:0]        mem_q
`ifdef DRAM_ARB_LOCK_EN
    ,
    input  logic [NUM_CH-1:0]        lock
`endif
);

    localparam int CH_W = ch_id_w(NUM_CH);
    localparam int LAT  = (RD_LATENCY < MIN_RD_LAT) ? MIN_RD_LAT :
                          (RD_LATENCY > MAX_RD_LAT) ? MAX_RD_LAT : RD_LATENCY;

    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_gnt_raw;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   w_win_id;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wren;
    logic [LAT-1:0]    r_pv;
    logic [CH_W-1:0]   r_pid [LAT];

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_rr (
        .i_req  (req),
        .i_mask (w_mask),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt_raw)
    );

    assign w_gnt = rst ? '0 : w_gnt_raw;

`ifdef DRAM_ARB_LOCK_EN
    arb_state_t      r_state;
    arb_state_t      w_state_next;
    logic [CH_W-1:0] r_lock_ch;
    logic [CH_W-1:0] w_lock_ch_next;

    // Mask depends only on registered state, so no loop through the grant.
    assign w_mask = (r_state == ARB_LOCKED) ?
                    ({{(NUM_CH-1){1'b0}}, 1'b1} << r_lock_ch) : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_next;
            r_lock_ch <= w_lock_ch_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_lock_ch_next = r_lock_ch;
        case (r_state)
            ARB_IDLE: begin
                if ((|w_gnt) && lock[w_win_id]) begin
                    w_state_next   = ARB_LOCKED;
                    w_lock_ch_next = w_win_id;
                end
            end
            ARB_LOCKED: begin
                if (!lock[r_lock_ch])
                    w_state_next = ARB_IDLE;
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end
`else
    assign w_mask = '1;
`endif

    always_comb begin
        w_win_id = '0;
        w_addr   = '0;
        w_wdata  = '0;
        w_wren   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_win_id = CH_W'(i);
                w_addr   = addr[i*ADDR_W +: ADDR_W];
                w_wdata  = wdata[i*DATA_W +: DATA_W];
                w_wren   = we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= CH_W'(NUM_CH - 1);
        else if (|w_gnt)
            r_ptr <= w_win_id;
    end

    // Read-id pipeline tracks the RAM latency; writes push an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= (|w_gnt) & ~w_wren;
            for (int s = 1; s < LAT; s++)
                r_pv[s] <= r_pv[s-1];
        end
        r_pid[0] <= w_win_id;
        for (int s = 1; s < LAT; s++)
            r_pid[s] <= r_pid[s-1];
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (!rst && r_pv[LAT-1]) begin
            rvalid[r_pid[LAT-1]] = 1'b1;
            rdata                = mem_q;
        end
    end

    assign gnt       = w_gnt;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign mem_wren  = w_wren;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter (3 channels, read latency 2) with a behavioural
// DRAM; lock sequence included when DRAM_ARB_LOCK_EN is defined.
module tb_dram_port_arbiter;

    localparam int L = 2;

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  w;
        logic [47:0] a;
        logic [23:0] d;
        logic [2:0]  g;
        logic        ew;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         due;
    } rd_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_q;
`ifdef DRAM_ARB_LOCK_EN
    logic [2:0]  lock;
`endif

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] addr_q;
    logic [7:0]  q1;

    rd_t sb[$];
    int  cyc   = 0;
    int  n_vec = 0;
    int  n_err = 0;
    vec_t tbl [15];

    dram_port_arbiter #(
        .NUM_CH     (3),
        .ADDR_W     (16),
        .DATA_W     (8),
        .RD_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
`ifdef DRAM_ARB_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM: address registered at the edge, one more output register (latency 2).
    always @(posedge clk) begin
        q1     <= ram[addr_q];
        addr_q <= mem_addr;
        if (mem_wren) ram[mem_addr] = mem_wdata;
    end
    assign mem_q = q1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w,
                                input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [2:0] g, input logic ew);
        vec_t v;
        v.r = r; v.w = w; v.a = {a2, a1, a0}; v.d = {d2, d1, d0}; v.g = g; v.ew = ew;
        return v;
    endfunction

    // Returned reads: compared every cycle against the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] erv;
        logic [7:0] erd;
        erv = '0;
        erd = '0;
        if (!rst && sb.size() > 0 && sb[0].due == cyc) begin
            erv = 3'b001 << sb[0].ch;
            erd = sb[0].data;
            void'(sb.pop_front());
        end
        chk("rvalid", 64'(rvalid), 64'(erv));
        chk("rdata", 64'(rdata), 64'(erd));
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t v, input string nm);
        int          k;
        logic [15:0] ea;
        logic [7:0]  ed;
        req = v.r; we = v.w; addr = v.a; wdata = v.d;
        @(negedge clk);
        k  = -1;
        ea = '0;
        ed = '0;
        for (int i = 0; i < 3; i++) begin
            if (v.g[i]) begin
                k  = i;
                ea = v.a[i*16 +: 16];
                ed = v.d[i*8 +: 8];
            end
        end
        chk({nm, ".gnt"}, 64'(gnt), 64'(v.g));
        chk({nm, ".wren"}, 64'(mem_wren), 64'(v.ew));
        chk({nm, ".maddr"}, 64'(mem_addr), 64'(ea));
        chk({nm, ".mwdata"}, 64'(mem_wdata), 64'(ed));
        if (k >= 0) begin
            if (v.w[k]) ref_mem[ea] = ed;
            else        sb.push_back('{k, ref_mem[ea], cyc + L});
        end
        $display("cyc %0d %s rst=%b req=%b we=%b gnt=%b wren=%b maddr=%h", cyc, nm, rst, req, we, gnt, mem_wren, mem_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef DRAM_ARB_LOCK_EN
        lock = '0;
`endif

        //           req     we      a0      a1      a2      d0     d1     d2     gnt     wren
        tbl[0]  = mk(3'b111, 3'b000, 16'h1,  16'h2,  16'h3,  8'h0,  8'h0,  8'h0,  3'b001, 1'b0);
        tbl[1]  = mk(3'b111, 3'b000, 16'h1,  16'h2,  16'h3,  8'h0,  8'h0,  8'h0,  3'b010, 1'b0);
        tbl[2]  = mk(3'b111, 3'b000, 16'h1,  16'h2,  16'h3,  8'h0,  8'h0,  8'h0,  3'b100, 1'b0);
        tbl[3]  = mk(3'b111, 3'b000, 16'h1,  16'h2,  16'h3,  8'h0,  8'h0,  8'h0,  3'b001, 1'b0);
        tbl[4]  = mk(3'b010, 3'b010, 16'h0,  16'h10, 16'h0,  8'h0,  8'hA5, 8'h0,  3'b010, 1'b1);
        tbl[5]  = mk(3'b010, 3'b000, 16'h0,  16'h10, 16'h0,  8'h0,  8'h0,  8'h0,  3'b010, 1'b0);
        tbl[6]  = mk(3'b101, 3'b001, 16'h10, 16'h0,  16'h10, 8'h3C, 8'h0,  8'h0,  3'b100, 1'b0);
        tbl[7]  = mk(3'b101, 3'b001, 16'h10, 16'h0,  16'h10, 8'h3C, 8'h0,  8'h0,  3'b001, 1'b1);
        tbl[8]  = mk(3'b100, 3'b000, 16'h0,  16'h0,  16'h10, 8'h0,  8'h0,  8'h0,  3'b100, 1'b0);
        tbl[9]  = mk(3'b000, 3'b000, 16'h7,  16'h8,  16'h9,  8'h1,  8'h2,  8'h3,  3'b000, 1'b0);
        tbl[10] = mk(3'b011, 3'b000, 16'h20, 16'h21, 16'h0,  8'h0,  8'h0,  8'h0,  3'b001, 1'b0);
        tbl[11] = mk(3'b011, 3'b000, 16'h20, 16'h21, 16'h0,  8'h0,  8'h0,  8'h0,  3'b010, 1'b0);
        tbl[12] = mk(3'b110, 3'b110, 16'h0,  16'h21, 16'h22, 8'h0,  8'h77, 8'h88, 3'b100, 1'b1);
        tbl[13] = mk(3'b010, 3'b010, 16'h0,  16'h21, 16'h22, 8'h0,  8'h77, 8'h88, 3'b010, 1'b1);
        tbl[14] = mk(3'b001, 3'b000, 16'h21, 16'h0,  16'h0,  8'h0,  8'h0,  8'h0,  3'b001, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            step(mk(3'b111, 3'b000, 16'h1, 16'h2, 16'h3, 8'h0, 8'h0, 8'h0, 3'b000, 1'b0), "reset");
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Read in flight when reset arrives must never come back.
        step(mk(3'b001, 3'b000, 16'h5, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 3'b001, 1'b0), "rmr_rd");
        rst = 1'b1;
        sb.delete();
        step(mk(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 3'b000, 1'b0), "rmr_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step(mk(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 3'b000, 1'b0), "rmr_idle");

        // Withdrawal: ch0 loses to ch1 once, then drops its request.
        step(mk(3'b001, 3'b001, 16'h30, 16'h0,  16'h0,  8'h01, 8'h0,  8'h0, 3'b001, 1'b1), "wd_a");
        step(mk(3'b011, 3'b010, 16'h31, 16'h30, 16'h0,  8'h0,  8'h99, 8'h0, 3'b010, 1'b1), "wd_b");
        step(mk(3'b000, 3'b000, 16'h31, 16'h0,  16'h0,  8'h0,  8'h0,  8'h0, 3'b000, 1'b0), "wd_c");
        step(mk(3'b000, 3'b000, 16'h31, 16'h0,  16'h0,  8'h0,  8'h0,  8'h0, 3'b000, 1'b0), "wd_d");
        step(mk(3'b100, 3'b000, 16'h0,  16'h0,  16'h30, 8'h0,  8'h0,  8'h0, 3'b100, 1'b0), "wd_e");

`ifdef DRAM_ARB_LOCK_EN
        lock = 3'b010;
        step(mk(3'b010, 3'b000, 16'h0, 16'h40, 16'h0, 8'h0, 8'h0, 8'h0, 3'b010, 1'b0), "lk_take");
        for (int i = 0; i < 10; i++)
            step(mk(3'b011, 3'b000, 16'h50, 16'h41, 16'h0, 8'h0, 8'h0, 8'h0, 3'b010, 1'b0), "lk_hold");
        lock = 3'b000;
        step(mk(3'b011, 3'b000, 16'h50, 16'h42, 16'h0, 8'h0, 8'h0, 8'h0, 3'b010, 1'b0), "lk_drop");
        step(mk(3'b001, 3'b000, 16'h50, 16'h0,  16'h0, 8'h0, 8'h0, 8'h0, 3'b001, 1'b0), "lk_free");
`endif

        for (int i = 0; i < L + 1; i++)
            step(mk(3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 3'b000, 1'b0), "drain");
        chk("drain.pending", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
